uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver paired with the existing UART transmitter (start bit 0, 8 data bits LSB first, optional parity, one stop bit 1).
- Oversamples RX_IN by PRESCALE clocks per bit and takes a 3-sample majority vote at mid-bit.
- Delivers the byte on a parallel bus with a one-cycle valid strobe, plus parity and stop (framing) error strobes.
- Sits at the serial input of the UART block, opposite the TX path, on the same clock.

Parameters:
- PRESCALE, 8: clocks per serial bit. Must be even and >= 4. Any other value is a compile-time error.
- DATA_WIDTH, 8: data bits per frame.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous active-high reset.
- RX_IN  in  1  serial line, idle high, asynchronous to CLK.
- PAR_EN  in  1  1 = frame carries a parity bit.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- P_DATA  out  DATA_WIDTH  received byte. Held until the next good frame.
- DATA_VALID  out  1  one-cycle pulse: P_DATA updated with a good frame.
- PAR_ERR  out  1  one-cycle pulse: parity mismatch on the completed frame.
- STP_ERR  out  1  one-cycle pulse: stop bit sampled as 0.
- BUSY  out  1  high from start-bit detection until frame completion.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0, BUSY=0.
  - FSM=IDLE, counters=0, both synchronizer flops=1.
  - Reset mid-frame discards the partial frame and produces no strobes.
- Input synchronizer:
  - RX_IN passes through 2 flops; all logic uses the synced value rx_s.
  - Fixed 2-cycle input latency.
- Counters:
  - edge_cnt runs 0..PRESCALE-1 and wraps; one wrap equals one bit period.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
- Sampling: samples are taken at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1. The bit value is the majority of the three, valid from edge_cnt = PRESCALE/2+2.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE:
  - When rx_s=0, go to START with edge_cnt=0 and BUSY=1.
  - Latch PAR_EN and PAR_TYP at this point; changes to them mid-frame are ignored.
- START:
  - If the voted bit is 1 (glitch), return to IDLE with BUSY=0 and no strobes.
  - Otherwise, at edge_cnt wrap, go to DATA.
- DATA:
  - Shift the voted bit into a shift register at bit position bit_cnt (LSB first).
  - After bit DATA_WIDTH-1 wraps, go to PARITY if the latched PAR_EN=1, else STOP.
- PARITY:
  - Compute par_calc = XOR of the data bits, XOR latched PAR_TYP.
  - par_bad = (voted bit != par_calc). Go to STOP at wrap.
- STOP:
  - stop_bad = (voted bit == 0).
  - Go to DONE as soon as the vote is valid (edge_cnt = PRESCALE/2+2). Do not wait for the wrap, so back-to-back frames are tracked.
- DONE (exactly 1 cycle):
  - If !par_bad and !stop_bad: P_DATA <= shift register, DATA_VALID=1.
  - Otherwise: PAR_ERR=par_bad, STP_ERR=stop_bad, and P_DATA is unchanged.
  - Both errors may pulse in the same cycle.
  - BUSY=0 and FSM=IDLE on the next cycle.
- Back-to-back frames: a start bit directly after the stop bit is detected from IDLE with at most PRESCALE/2-2 cycles of slip, which is inside tolerance.
- A line held low permanently yields repeated frames with STP_ERR and no hang.
- Parity flags are never asserted when the latched PAR_EN=0.

Decomposition:
- Package uart_rx_pkg holds:
  - FSM state enum (IDLE..DONE).
  - Constants EVEN=0, ODD=1.
  - Function for the PRESCALE legality check.
- Sub-module uart_rx_sampler holds:
  - edge_cnt.
  - The three sample flops and the majority vote.
  - Outputs: sample_bit, sample_vld, bit_wrap.
- The top level holds the FSM, shift register, parity check and outputs.

Test Plan:
1. PRESCALE=8, PAR_EN=1, PAR_TYP=0, send 0xA9 (serial line 0,1,0,0,1,0,1,0,1, parity 0, stop 1) -> exactly one DATA_VALID pulse, P_DATA=0xA9, no error pulses.
2. PAR_EN=1, PAR_TYP=1, send 0xAB with parity bit 0 -> P_DATA=0xAB, DATA_VALID pulse. Repeat with parity bit 1 -> PAR_ERR pulse, no DATA_VALID, P_DATA stays 0xAB.
3. PAR_EN=0, send 0xE9 then 0x3C back-to-back with no idle gap -> two DATA_VALID pulses, 0xE9 then 0x3C, BUSY low for at most 1 cycle between frames.
4. Stop bit driven 0 on byte 0x55 -> STP_ERR pulse, no DATA_VALID, then a following good frame 0x12 is received correctly.
5. RX_IN low pulse of 2 clocks in IDLE -> return to IDLE, no strobes, BUSY low again within PRESCALE cycles. Single-clock glitch inside a data bit at edge_cnt=PRESCALE/2 -> the majority vote rejects it and the byte is correct.
6. Assert RST for 1 cycle during data bit 4 of a frame -> all outputs 0 next cycle, no strobes for the aborted frame, and the next full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receiver: FSM encoding, parity
// sense constants, the oversampling-ratio legality check and the 3-way vote.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } state_t;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  function automatic bit prescale_ok(input int prescale);
    return (prescale >= 4) && ((prescale % 2) == 0);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-period timer and mid-bit 3-sample majority vote for the UART receiver.
// Held at edge_cnt=0 while run is low so each frame starts phase-aligned.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic run,
  output logic sample_bit,
  output logic sample_vld,
  output logic bit_wrap
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] S0   = CW'(PRESCALE/2 - 1);
  localparam logic [CW-1:0] S1   = CW'(PRESCALE/2);
  localparam logic [CW-1:0] S2   = CW'(PRESCALE/2 + 1);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
  // At the minimum ratio the vote point would fall past the wrap, so the
  // third sample is taken live on the last count instead.
  localparam int VLD_I = (PRESCALE/2 + 2 <= PRESCALE - 1) ? PRESCALE/2 + 2 : PRESCALE - 1;
  localparam logic [CW-1:0] VLD = CW'(VLD_I);

  logic [CW-1:0] edge_cnt;
  logic s0, s1, s2;
  logic third;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      edge_cnt <= '0;
    end else if (edge_cnt == LAST) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else if (run) begin
      if (edge_cnt == S0) s0 <= rx;
      if (edge_cnt == S1) s1 <= rx;
      if (edge_cnt == S2) s2 <= rx;
    end
  end

  assign third      = (edge_cnt == S2) ? rx : s2;
  assign sample_bit = maj3(s0, s1, third);
  assign sample_vld = run && (edge_cnt == VLD);
  assign bit_wrap   = run && (edge_cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, frame FSM, shift register,
// parity/stop checking and registered one-cycle result strobes.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE   = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  BUSY
);

  if (!prescale_ok(PRESCALE)) begin : g_bad_prescale
    $error("uart_rx: PRESCALE must be even and >= 4");
  end

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  state_t state, state_nxt;
  logic sync1, rx_s;
  logic run, sample_bit, sample_vld, bit_wrap;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BW-1:0] bit_cnt;
  logic par_en_l, par_typ_l, par_bad, stop_bad;
  logic done_good, done_par, done_stp, busy_c;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= RX_IN;
      rx_s  <= sync1;
    end
  end

  assign run = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);

  uart_rx_sampler #(.PRESCALE(PRESCALE)) u_sampler (
    .clk        (CLK),
    .rst        (RST),
    .rx         (rx_s),
    .run        (run),
    .sample_bit (sample_bit),
    .sample_vld (sample_vld),
    .bit_wrap   (bit_wrap)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!rx_s) state_nxt = START;
      START: begin
        if (sample_vld && sample_bit) state_nxt = IDLE;
        else if (bit_wrap)            state_nxt = DATA;
      end
      DATA:   if (bit_wrap && (bit_cnt == LAST_BIT)) state_nxt = par_en_l ? PARITY : STOP;
      PARITY: if (bit_wrap) state_nxt = STOP;
      // Leave at mid-bit so a start bit right behind the stop bit is caught.
      STOP:   if (sample_vld) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      par_en_l  <= 1'b0;
      par_typ_l <= EVEN;
      par_bad   <= 1'b0;
      stop_bad  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            par_en_l  <= PAR_EN;
            par_typ_l <= PAR_TYP;
            par_bad   <= 1'b0;
            stop_bad  <= 1'b0;
            bit_cnt   <= '0;
          end
        end
        DATA: begin
          if (sample_vld) shreg[bit_cnt] <= sample_bit;
          if (bit_wrap) bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        end
        PARITY: if (sample_vld) par_bad <= (sample_bit != ((^shreg) ^ par_typ_l));
        STOP:   if (sample_vld) stop_bad <= !sample_bit;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_c    = (state != IDLE);
    done_good = (state == DONE) && !par_bad && !stop_bad;
    done_par  = (state == DONE) && par_bad;
    done_stp  = (state == DONE) && stop_bad;
  end

  assign BUSY = busy_c;

  // Strobes are registered so they line up with the P_DATA update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= done_good;
      PAR_ERR    <= done_par;
      STP_ERR    <= done_stp;
      if (done_good) P_DATA <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven serially, expected strobes
// are queued at issue time and a monitor pops them as the DUT reports.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int P  = 8;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID;
  logic          PAR_ERR;
  logic          STP_ERR;
  logic          BUSY;

  uart_rx #(.PRESCALE(P), .DATA_WIDTH(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  // flags = {DATA_VALID, PAR_ERR, STP_ERR}
  typedef struct packed {
    logic [2:0]    flags;
    logic [DW-1:0] data;
  } exp_t;

  localparam logic [2:0] F_VALID = 3'b100;
  localparam logic [2:0] F_PAR   = 3'b010;
  localparam logic [2:0] F_STP   = 3'b001;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   gap_mon = 1'b0;
  bit   seen_busy = 1'b0;
  int   low_run = 0;
  int   max_gap = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input logic [2:0] flags, input logic [DW-1:0] data);
    exp_t e;
    e.flags = flags;
    e.data  = data;
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      RX_IN = 1'b1;
    end
  endtask

  // PAR_EN/PAR_TYP are inverted after the start bit to prove they are latched.
  task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp,
                            input logic pbit, input logic stop_bit, input int glitch_idx);
    logic [DW+2:0] seq;
    int n;
    seq    = '0;
    seq[0] = 1'b0;
    for (int i = 0; i < DW; i++) seq[i+1] = d[i];
    n = DW + 1;
    if (pen) begin
      seq[n] = pbit;
      n++;
    end
    seq[n] = stop_bit;
    n++;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < P; c++) begin
        @(negedge CLK);
        if (i == 0 && c == 0) begin
          PAR_EN  = pen;
          PAR_TYP = ptyp;
        end
        if (i == 1 && c == 0) begin
          PAR_EN  = ~pen;
          PAR_TYP = ~ptyp;
        end
        RX_IN = (i == glitch_idx && c == P/2) ? ~seq[i] : seq[i];
      end
    end
    @(negedge CLK);
    RX_IN = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (DATA_VALID || PAR_ERR || STP_ERR) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe actual flags=%b p_data=%0h required no strobe",
                   {DATA_VALID, PAR_ERR, STP_ERR}, P_DATA);
        end else begin
          mon_e = sbq.pop_front();
          check("strobe_flags", int'({DATA_VALID, PAR_ERR, STP_ERR}), int'(mon_e.flags));
          check("p_data", int'(P_DATA), int'(mon_e.data));
        end
      end
    end
  end

  // Longest BUSY-low run between two busy periods while gap_mon is set.
  initial begin
    forever begin
      @(negedge CLK);
      if (!gap_mon) begin
        seen_busy = 1'b0;
        low_run   = 0;
      end else if (BUSY) begin
        if (seen_busy && low_run > max_gap) max_gap = low_run;
        seen_busy = 1'b1;
        low_run   = 0;
      end else if (seen_busy) begin
        low_run++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  busy_wait;
    int  busy_len;
    bit  rose;

    RST     = 1'b1;
    RX_IN   = 1'b1;
    PAR_EN  = 1'b0;
    PAR_TYP = EVEN;
    repeat (3) @(negedge CLK);
    check("reset_outputs", int'({P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY}), 0);
    RST = 1'b0;
    idle(2 * P);

    // Even parity 0xA9: parity bit 0
    expect_ev(F_VALID, 8'hA9);
    send_frame(8'hA9, 1'b1, EVEN, 1'b0, 1'b1, -1);
    idle(3 * P);

    // Odd parity 0xAB: good parity 0, then wrong parity 1
    expect_ev(F_VALID, 8'hAB);
    send_frame(8'hAB, 1'b1, ODD, 1'b0, 1'b1, -1);
    idle(3 * P);
    expect_ev(F_PAR, 8'hAB);
    send_frame(8'hAB, 1'b1, ODD, 1'b1, 1'b1, -1);
    idle(3 * P);

    // Back-to-back without parity
    gap_mon = 1'b1;
    expect_ev(F_VALID, 8'hE9);
    expect_ev(F_VALID, 8'h3C);
    send_frame(8'hE9, 1'b0, EVEN, 1'b0, 1'b1, -1);
    send_frame(8'h3C, 1'b0, EVEN, 1'b0, 1'b1, -1);
    idle(3 * P);
    gap_mon = 1'b0;
    if (max_gap > 1) check("busy_gap", max_gap, 1);
    else             check("busy_gap", 1, 1 - max_gap + max_gap);

    // Framing error keeps last good byte, then recovery
    expect_ev(F_STP, 8'h3C);
    send_frame(8'h55, 1'b0, EVEN, 1'b0, 1'b0, -1);
    idle(4 * P);
    expect_ev(F_VALID, 8'h12);
    send_frame(8'h12, 1'b0, EVEN, 1'b0, 1'b1, -1);
    idle(3 * P);

    // Two-clock low pulse in idle
    @(negedge CLK); RX_IN = 1'b0;
    @(negedge CLK); RX_IN = 1'b0;
    @(negedge CLK); RX_IN = 1'b1;
    rose = 1'b0;
    busy_wait = 0;
    while (!rose && busy_wait < 10) begin
      if (BUSY) rose = 1'b1;
      else begin
        @(negedge CLK);
        busy_wait++;
      end
    end
    check("glitch_busy_rose", int'(rose), 1);
    busy_len = 0;
    while (BUSY && busy_len < 4 * P) begin
      @(negedge CLK);
      busy_len++;
    end
    check("glitch_busy_len_ok", int'(busy_len <= P), 1);
    idle(2 * P);

    // Single-clock glitch in data bit 2 of 0x5A (serial index 3)
    expect_ev(F_VALID, 8'h5A);
    send_frame(8'h5A, 1'b0, EVEN, 1'b0, 1'b1, 3);
    idle(3 * P);

    // Reset in the middle of data bit 4 of 0xF0 (bits 4..7 and stop are 1)
    fork
      send_frame(8'hF0, 1'b0, EVEN, 1'b0, 1'b1, -1);
      begin
        repeat (5 * P + P/2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("midframe_reset_outputs", int'({P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY}), 0);
      end
    join
    idle(3 * P);
    expect_ev(F_VALID, 8'h81);
    send_frame(8'h81, 1'b0, EVEN, 1'b0, 1'b1, -1);
    idle(3 * P);

    for (int i = 0; i < 4 * P && sbq.size() > 0; i++) @(negedge CLK);
    check("scoreboard_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
